mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single memory/peripheral bus (ROM, RAM, GPIO/IO latch) between the CPU instruction-fetch port
//  and the load/store data port. Decodes the target, drives chip selects, output enable and write enable,
//  and inserts per-target wait states. Returns read data with a one-cycle ack pulse per request.
//  Sits between the CPU core and the ROM, RAM and IO blocks; the tristate drivers stay inside those blocks.
// PARAMETERS
//  ADDR_W      32       address width, both ports and bus
//  DATA_W      64       data width, both ports and bus
//  ROM_WAIT    2        extra ACCESS cycles for ROM (0..15)
//  RAM_WAIT    1        extra ACCESS cycles for RAM (0..15)
//  IO_WAIT     0        extra ACCESS cycles for IO (0..15)
//  IO_LO       'h00FE   first data address decoded as IO (direction register)
//  IO_HI       'h00FF   last data address decoded as IO (port register)
//  FAIR_LIMIT  4        consecutive data grants with fetch pending before fetch is forced (1..15)
// PORTS
//  clock      in   1        single clock, rising edge
//  reset_n    in   1        asynchronous, active-low reset
//  f_req      in   1        fetch request; held with f_addr stable until f_ack
//  f_addr     in   ADDR_W   fetch address; always decodes to ROM
//  f_ack      out  1        one-cycle pulse; f_rdata valid in the same cycle
//  f_rdata    out  DATA_W   registered fetch read data
//  d_req      in   1        data request; held with d_we/d_addr/d_wdata stable until d_ack
//  d_we       in   1        1 = store, 0 = load
//  d_addr     in   ADDR_W   data address
//  d_wdata    in   DATA_W   store data
//  d_ack      out  1        one-cycle pulse; d_rdata valid in the same cycle (loads)
//  d_rdata    out  DATA_W   registered load data
//  bus_addr   out  ADDR_W   shared address
//  bus_wdata  out  DATA_W   shared write data
//  bus_rdata  in   DATA_W   shared read data from the selected target
//  bus_we     out  1        write strobe
//  bus_oe     out  1        output enable, reads only
//  rom_cs     out  1        ROM chip select
//  ram_cs     out  1        RAM chip select
//  io_cs      out  1        IO chip select
//  busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; f_ack, d_ack, bus_we, bus_oe, all CS = 0; bus_addr, bus_wdata,
//   f_rdata, d_rdata = 0; wait counter = 0; fairness counter = 0. Release mid-access aborts it with no ack.
//  FSM: IDLE -> ACCESS -> TURN -> IDLE.
//  IDLE: arbitrate on the sampled reqs:
//   - data only -> grant data; fetch only -> grant fetch.
//   - both -> grant data, unless fair_cnt == FAIR_LIMIT, then grant fetch.
//   - On grant, register addr/wdata/we and decode. Fetch -> rom_cs. Data with IO_LO <= addr <= IO_HI -> io_cs.
//     Any other data address -> ram_cs. Load wait counter with the target WAIT and go to ACCESS.
//  ACCESS: exactly one CS high; bus_oe = ~we, bus_we = we. Counter decrements each edge.
//   On the edge where counter == 0: latch bus_rdata into the granted port's rdata (loads/fetches only),
//   set that port's ack, and go to TURN.
//  TURN: all CS/oe/we low (bus turnaround); ack high for this one cycle only; reqs ignored.
//  Latency: ack is visible WAIT+1 edges after the IDLE edge that granted. Back-to-back throughput is one access per WAIT+3 cycles.
//  Requester drops req on the edge ending its ack cycle. A req still high in IDLE starts a new access.
//  Fairness: fair_cnt increments on each data grant while f_req is high; saturates at FAIR_LIMIT;
//   clears on a fetch grant or whenever f_req is low in IDLE.
//  Stores: rdata is not updated; d_ack still pulses. Fetch never asserts bus_we.
//  Req changes during ACCESS/TURN do not affect the access in flight (registered copies drive the bus).
//  Simultaneous f_ack and d_ack is impossible.
// TESTING
//  1 Fetch only, f_addr=0x0004, ROM_WAIT=2, bus_rdata=0xB200_1FE0 -> rom_cs 3 cycles; f_ack 3 edges after grant; f_rdata=0xB2001FE0.
//  2 Store d_addr=0x00FF, d_wdata=4 -> io_cs + bus_we 1 cycle (IO_WAIT=0), bus_oe=0, d_ack pulse, d_rdata unchanged.
//  3 Load d_addr=0x0100 -> ram_cs, bus_oe for 2 cycles; d_rdata = bus_rdata; io_cs/rom_cs never high.
//  4 f_req and d_req held high continuously -> grant order D,D,D,D,F,D,D,D,D,F...; no two CS high at once; TURN between every pair.
//  5 reset_n low in ACCESS cycle 1 of a ROM read -> all outputs 0 immediately; after release with f_req high, a fresh full-latency fetch occurs.
//  6 Req held high through its ack -> second identical access starts after TURN; two acks, separated by WAIT+3 cycles.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the ROM/RAM/IO bus between the fetch and data ports with per-target wait states
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ROM_WAIT = 2,
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT = 0,
  parameter logic [ADDR_W-1:0] IO_LO = 'h00FE,
  parameter logic [ADDR_W-1:0] IO_HI = 'h00FF,
  parameter int FAIR_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_we,
  output logic              bus_oe,
  output logic              rom_cs,
  output logic              ram_cs,
  output logic              io_cs,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, TURN = 2'd2;
  logic [1:0] state;
  logic [3:0] wait_cnt, fair_cnt;
  logic fair_full, gnt_d, gnt_f, is_io;
  always_comb begin
    fair_full = fair_cnt == 4'(FAIR_LIMIT);
    gnt_d = d_req && !(f_req && fair_full);
    gnt_f = f_req && !gnt_d;
    is_io = d_addr >= IO_LO && d_addr <= IO_HI;
  end
  assign busy = state != IDLE;
  // rom_cs doubles as the "granted port is fetch" flag while in ACCESS
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      wait_cnt <= '0;
      fair_cnt <= '0;
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      f_rdata <= '0;
      d_rdata <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_we <= 1'b0;
      bus_oe <= 1'b0;
      rom_cs <= 1'b0;
      ram_cs <= 1'b0;
      io_cs <= 1'b0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      if (state == IDLE) begin
        fair_cnt <= (!f_req || gnt_f) ? '0 : (gnt_d && !fair_full) ? fair_cnt + 4'd1 : fair_cnt;
        if (gnt_f || gnt_d) begin
          state <= ACCESS;
          bus_addr <= gnt_f ? f_addr : d_addr;
          bus_wdata <= gnt_d ? d_wdata : bus_wdata;
          bus_we <= gnt_d && d_we;
          bus_oe <= gnt_f || !d_we;
          rom_cs <= gnt_f;
          ram_cs <= gnt_d && !is_io;
          io_cs <= gnt_d && is_io;
          wait_cnt <= gnt_f ? 4'(ROM_WAIT) : is_io ? 4'(IO_WAIT) : 4'(RAM_WAIT);
        end
      end else if (state == ACCESS) begin
        if (wait_cnt == '0) begin
          state <= TURN;
          f_ack <= rom_cs;
          d_ack <= !rom_cs;
          if (!bus_we && rom_cs) f_rdata <= bus_rdata;
          if (!bus_we && !rom_cs) d_rdata <= bus_rdata;
          bus_we <= 1'b0;
          bus_oe <= 1'b0;
          rom_cs <= 1'b0;
          ram_cs <= 1'b0;
          io_cs <= 1'b0;
        end else wait_cnt <= wait_cnt - 4'd1;
      end else state <= IDLE;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of arbitration, decode, wait states, fairness and reset abort
module tb_mem_bus_arbiter;
  logic clock = 1'b0, reset_n = 1'b1;
  logic f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0;
  logic [63:0] d_wdata = '0, bus_rdata = '0;
  logic f_ack, d_ack, bus_we, bus_oe, rom_cs, ram_cs, io_cs, busy;
  logic [63:0] f_rdata, d_rdata, bus_wdata;
  logic [31:0] bus_addr;
  int checks = 0, errors = 0;

  mem_bus_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_we(bus_we), .bus_oe(bus_oe), .rom_cs(rom_cs), .ram_cs(ram_cs), .io_cs(io_cs), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Steps negedges until an ack appears, then checks latency, ack source, CS usage and TURN state.
  task automatic run(input string tag, input int lat, input logic is_f, input logic [2:0] cs_exp,
                     input int cs_cyc, input int oe_cyc, input int we_cyc);
    int n = 0, c = 0, o = 0, w = 0;
    logic [2:0] seen = '0;
    logic bad = 1'b0;
    do begin
      @(negedge clock);
      n++;
      if (rom_cs || ram_cs || io_cs) c++;
      seen |= {rom_cs, ram_cs, io_cs};
      o += int'(bus_oe);
      w += int'(bus_we);
      if ($countones({rom_cs, ram_cs, io_cs}) > 1 || (f_ack && d_ack) || (bus_we && rom_cs)) bad = 1'b1;
    end while (!(f_ack || d_ack) && n < 40);
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " f_ack"}, 64'(f_ack), 64'(is_f));
    chk({tag, " d_ack"}, 64'(d_ack), 64'(!is_f));
    chk({tag, " cs target"}, 64'(seen), 64'(cs_exp));
    chk({tag, " cs cycles"}, 64'(c), 64'(cs_cyc));
    chk({tag, " oe cycles"}, 64'(o), 64'(oe_cyc));
    chk({tag, " we cycles"}, 64'(w), 64'(we_cyc));
    chk({tag, " turn idle bus"}, 64'({rom_cs, ram_cs, io_cs, bus_oe, bus_we}), 64'(0));
    chk({tag, " protocol"}, 64'(bad), 64'(0));
  endtask

  task automatic settle(input string tag);
    f_req = 1'b0;
    d_req = 1'b0;
    @(negedge clock);
    chk({tag, " ack pulse"}, 64'({f_ack, d_ack}), 64'(0));
    chk({tag, " idle"}, 64'(busy), 64'(0));
  endtask

  task automatic data_op(input string tag, input logic we, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [63:0] rd, input logic [2:0] cs_exp, input int wt);
    logic [63:0] old;
    old = d_rdata;
    d_we = we;
    d_addr = addr;
    d_wdata = wd;
    bus_rdata = rd;
    d_req = 1'b1;
    run(tag, wt + 2, 1'b0, cs_exp, wt + 1, we ? 0 : wt + 1, we ? wt + 1 : 0);
    chk({tag, " d_rdata"}, d_rdata, we ? old : rd);
    chk({tag, " bus_addr"}, 64'(bus_addr), 64'(addr));
    if (we) chk({tag, " bus_wdata"}, bus_wdata, wd);
    settle(tag);
  endtask

  initial begin
    logic [9:0] order;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset outputs", 64'({f_ack, d_ack, bus_we, bus_oe, rom_cs, ram_cs, io_cs, busy}), 64'(0));
    chk("reset data", f_rdata | d_rdata | bus_wdata | 64'(bus_addr), 64'(0));
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle after reset", 64'(busy), 64'(0));

    f_addr = 32'h0004;
    bus_rdata = 64'hB200_1FE0;
    f_req = 1'b1;
    run("fetch", 4, 1'b1, 3'b100, 3, 3, 0);
    chk("fetch f_rdata", f_rdata, 64'hB200_1FE0);
    chk("fetch bus_addr", 64'(bus_addr), 64'h4);
    chk("fetch d_rdata untouched", d_rdata, 64'(0));
    settle("fetch");

    data_op("io store", 1'b1, 32'h00FF, 64'h4, 64'h1234, 3'b001, 0);
    data_op("ram load", 1'b0, 32'h0100, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 3'b010, 1);
    data_op("io low edge", 1'b0, 32'h00FE, 64'h0, 64'h55, 3'b001, 0);
    data_op("ram below io", 1'b0, 32'h00FD, 64'h0, 64'h77, 3'b010, 1);
    data_op("ram store", 1'b1, 32'h0100, 64'hA5A5, 64'h99, 3'b010, 1);

    // both requesters held: data wins four times, then fetch is forced
    d_we = 1'b0;
    d_addr = 32'h0100;
    bus_rdata = 64'h1111;
    f_req = 1'b1;
    d_req = 1'b1;
    order = '0;
    for (int i = 0; i < 10; i++) begin
      logic fx;
      fx = (i == 4 || i == 9);
      run($sformatf("fair %0d", i), (i == 0 ? 2 : 3) + (fx ? 2 : 1), fx, fx ? 3'b100 : 3'b010,
          fx ? 3 : 2, fx ? 3 : 2, 0);
      order[i] = f_ack;
    end
    chk("fair order", 64'(order), 64'h210);
    settle("fair");

    f_addr = 32'h0008;
    bus_rdata = 64'hABCD;
    f_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("abort in access", 64'({rom_cs, busy}), 64'h3);
    reset_n = 1'b0;
    #1;
    chk("abort outputs", 64'({f_ack, d_ack, bus_we, bus_oe, rom_cs, ram_cs, io_cs, busy}), 64'(0));
    chk("abort data", f_rdata | d_rdata | bus_wdata | 64'(bus_addr), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    bus_rdata = 64'h5A5A;
    run("post reset fetch", 4, 1'b1, 3'b100, 3, 3, 0);
    chk("post reset f_rdata", f_rdata, 64'h5A5A);

    bus_rdata = 64'h6B6B;
    run("held fetch", 5, 1'b1, 3'b100, 3, 3, 0);
    chk("held fetch f_rdata", f_rdata, 64'h6B6B);
    settle("held fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
